// File: rtl/seconds_stopwatch.sv
// Seconds stopwatch: debounced run/pause and clear keys, a one-second prescaler,
// and a 0..MAX_COUNT seconds counter with a wrap pulse for a later minutes stage.
module seconds_stopwatch #(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_COUNT       = 59
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       KEY_RUN,
    input  logic       KEY_CLR,
    output logic [5:0] SECONDS,
    output logic       RUNNING,
    output logic       WRAP
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]    SEC_MAX = 6'(MAX_COUNT);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // bit 0 = run key, bit 1 = clear key
    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {KEY_CLR, KEY_RUN};

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_key
            logic          sync1_q;
            logic          key_s_q;
            logic          key_db_q;
            logic          key_db_dly_q;
            logic [DW-1:0] db_cnt_q;
            logic [DW-1:0] db_cnt_d;
            logic          key_db_d;

            always_comb begin
                db_cnt_d = db_cnt_q;
                key_db_d = key_db_q;
                if (key_s_q == key_db_q) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    key_db_d = key_s_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge CLOCK_50 or negedge RST_N) begin
                if (!RST_N) begin
                    sync1_q      <= 1'b1;
                    key_s_q      <= 1'b1;
                    key_db_q     <= 1'b1;
                    key_db_dly_q <= 1'b1;
                    db_cnt_q     <= '0;
                end else begin
                    sync1_q      <= key_raw[k];
                    key_s_q      <= sync1_q;
                    key_db_q     <= key_db_d;
                    key_db_dly_q <= key_db_q;
                    db_cnt_q     <= db_cnt_d;
                end
            end

            // Press fires on the debounced falling edge only; release is silent.
            assign press[k] = key_db_dly_q & ~key_db_q;
        end
    endgenerate

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [5:0]    sec_q;
    logic          wrap_q;
    logic          running_q;
    logic          tick;

    assign tick = (state_q == RUN) && (presc_q == PS_LAST);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            sec_q     <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (state_q == RUN) begin
                if (tick) begin
                    presc_q <= '0;
                    if (sec_q >= SEC_MAX) begin
                        sec_q  <= '0;
                        wrap_q <= 1'b1;
                    end else begin
                        sec_q <= sec_q + 1'b1;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
            // Later assignments override the tick update: clear beats everything,
            // and a run press still lets a coincident tick land before pausing.
            if (press[1]) begin
                state_q   <= IDLE;
                presc_q   <= '0;
                sec_q     <= '0;
                wrap_q    <= 1'b0;
                running_q <= 1'b0;
            end else if (press[0]) begin
                case (state_q)
                    IDLE: begin
                        state_q   <= RUN;
                        presc_q   <= '0;
                        running_q <= 1'b1;
                    end
                    RUN: begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                    PAUSE: begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SECONDS = sec_q;
    assign RUNNING = running_q;
    assign WRAP    = wrap_q;

endmodule

// File: tb/tb_seconds_stopwatch.sv
// Directed bench for seconds_stopwatch with a short prescaler and debounce window.
module tb_seconds_stopwatch;

    localparam int TD = 4;
    localparam int DC = 3;
    localparam int MC = 59;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_run = 1'b1;
    logic       key_clr = 1'b1;
    logic [5:0] sec;
    logic       running;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seconds_stopwatch #(
        .TICK_DIV(TD),
        .DEBOUNCE_CYCLES(DC),
        .MAX_COUNT(MC)
    ) dut (
        .CLOCK_50(clk),
        .RST_N(rst_n),
        .KEY_RUN(key_run),
        .KEY_CLR(key_clr),
        .SECONDS(sec),
        .RUNNING(running),
        .WRAP(wrap)
    );

    typedef struct {
        logic       run;
        logic       clr;
        logic [5:0] sec;
        logic       running;
        logic       wrap;
    } vec_t;

    vec_t vt[20];
    byte unsigned start_sec[20] = '{0,0,0,0,0,0,0,0,0,1,1,1,1,2,2,2,2,3,3,3};

    task automatic chk(input string name, input logic [5:0] es, input logic er, input logic ew);
        checks++;
        if (sec !== es || running !== er || wrap !== ew) begin
            errors++;
            $display("FAIL %s: got sec=%0d run=%0b wrap=%0b, want sec=%0d run=%0b wrap=%0b",
                     name, sec, running, wrap, es, er, ew);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic cyc(input logic r, input logic c);
        key_run = r;
        key_clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_sec(input logic [5:0] target, input string name);
        int n;
        n = 0;
        while (sec !== target && n < 400) begin
            cyc(1'b1, 1'b1);
            n++;
            checks++;
            if (sec > 6'(MC) || wrap !== 1'b0 || running !== 1'b1) begin
                errors++;
                $display("FAIL %s_run: got sec=%0d run=%0b wrap=%0b, want sec<=%0d run=1 wrap=0",
                         name, sec, running, wrap, MC);
            end
        end
        checks++;
        if (sec !== target) begin
            errors++;
            $display("FAIL %s: got sec=%0d, want sec=%0d within 400 cycles", name, sec, target);
        end
    endtask

    initial begin
        for (int i = 0; i < 20; i++) begin
            vt[i].run     = (i < 10) ? 1'b0 : 1'b1;
            vt[i].clr     = 1'b1;
            vt[i].sec     = 6'(start_sec[i]);
            vt[i].running = (i >= 5);
            vt[i].wrap    = 1'b0;
        end

        // Asynchronous reset, asserted between edges
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_held", 0, 0, 0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1);
        chk("reset_release", 0, 0, 0);
        repeat (2) begin
            cyc(1'b1, 1'b1);
            chk("idle", 0, 0, 0);
        end

        // Start: run key low for 10 cycles
        for (int i = 0; i < 20; i++) begin
            cyc(vt[i].run, vt[i].clr);
            chk($sformatf("start[%0d]", i), vt[i].sec, vt[i].running, vt[i].wrap);
        end

        // Wrap at MAX_COUNT
        wait_sec(6'd59, "to59");
        repeat (3) begin
            cyc(1'b1, 1'b1);
            chk("pre_wrap", 59, 1, 0);
        end
        cyc(1'b1, 1'b1);
        chk("wrap_pulse", 0, 1, 1);
        repeat (3) begin
            cyc(1'b1, 1'b1);
            chk("post_wrap", 0, 1, 0);
        end
        cyc(1'b1, 1'b1);
        chk("after_wrap", 1, 1, 0);

        // Pause landing with prescaler at 2
        cyc(1'b0, 1'b1); chk("pause_p1", 1, 1, 0);
        cyc(1'b0, 1'b1); chk("pause_p2", 1, 1, 0);
        cyc(1'b0, 1'b1); chk("pause_p3", 1, 1, 0);
        cyc(1'b0, 1'b1); chk("pause_p4", 2, 1, 0);
        cyc(1'b0, 1'b1); chk("pause_p5", 2, 1, 0);
        cyc(1'b1, 1'b1); chk("paused", 2, 0, 0);
        repeat (50) begin
            cyc(1'b1, 1'b1);
            chk("pause_hold", 2, 0, 0);
        end

        // Bounce on run key while paused: never stable for 3 cycles
        repeat (7) begin
            cyc(1'b0, 1'b1); chk("bounce", 2, 0, 0);
            cyc(1'b0, 1'b1); chk("bounce", 2, 0, 0);
            cyc(1'b1, 1'b1); chk("bounce", 2, 0, 0);
        end
        repeat (5) begin
            cyc(1'b1, 1'b1);
            chk("bounce_after", 2, 0, 0);
        end

        // Resume keeps the partial second
        repeat (5) begin
            cyc(1'b0, 1'b1);
            chk("resume_press", 2, 0, 0);
        end
        cyc(1'b1, 1'b1); chk("resume_run", 2, 1, 0);
        cyc(1'b1, 1'b1); chk("resume_1st", 2, 1, 0);
        cyc(1'b1, 1'b1); chk("resume_2nd", 3, 1, 0);

        // Clear and run pressed together at SECONDS=30
        wait_sec(6'd29, "to29");
        cyc(1'b0, 1'b0); chk("both_p1", 29, 1, 0);
        cyc(1'b0, 1'b0); chk("both_p2", 29, 1, 0);
        cyc(1'b0, 1'b0); chk("both_p3", 29, 1, 0);
        cyc(1'b0, 1'b0); chk("both_p4", 30, 1, 0);
        cyc(1'b0, 1'b0); chk("both_p5", 30, 1, 0);
        cyc(1'b1, 1'b1); chk("clear_wins", 0, 0, 0);
        repeat (6) begin
            cyc(1'b1, 1'b1);
            chk("cleared_idle", 0, 0, 0);
        end

        // Fresh start from 0 with a full first step
        repeat (5) begin
            cyc(1'b0, 1'b1);
            chk("restart_press", 0, 0, 0);
        end
        cyc(1'b1, 1'b1); chk("restart_run", 0, 1, 0);
        repeat (3) begin
            cyc(1'b1, 1'b1);
            chk("restart_step", 0, 1, 0);
        end
        cyc(1'b1, 1'b1); chk("restart_first", 1, 1, 0);

        // Reset mid-run at 17
        wait_sec(6'd17, "to17");
        #2 rst_n = 1'b0;
        #1 chk("reset_midrun", 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_midrun_held", 0, 0, 0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1);
        chk("reset_midrun_release", 0, 0, 0);
        repeat (6) begin
            cyc(1'b1, 1'b1);
            chk("reset_idle", 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000 ns");
        $fatal(1);
    end

endmodule
